// File: rtl/muldiv_pkg.sv
// Shared operation and state encodings for the HI/LO multiply/divide controller.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit: request, mthi/mtlo writes, HI/LO and status.
interface muldiv_if #(
    parameter int W = 32
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_unsup;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div_unsup
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div_unsup
    );
endinterface

// File: rtl/muldiv_dp.sv
// One shift-add multiply step or one restoring-divide step per cycle on unsigned magnitudes.
// The divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_dp #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
`ifdef MULDIV_DIV_EN
    input  logic         is_div,
`endif
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo
);

    // acc: product high half / remainder; sh: multiplier shifting out / quotient shifting in
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] sh_q, sh_d;
    logic [W-1:0] m_q, m_d;
    logic [W:0]   add_sum;
`ifdef MULDIV_DIV_EN
    logic [W:0]   rem_sh;
    logic [W:0]   rem_diff;
`endif

    always_comb begin
        acc_d   = acc_q;
        sh_d    = sh_q;
        m_d     = m_q;
        add_sum = sh_q[0] ? ({1'b0, acc_q} + {1'b0, m_q}) : {1'b0, acc_q};
`ifdef MULDIV_DIV_EN
        rem_sh   = {acc_q, sh_q[W-1]};
        rem_diff = rem_sh - {1'b0, m_q};
`endif
        if (load) begin
            acc_d = '0;
            sh_d  = opa;
            m_d   = opb;
        end else if (step) begin
`ifdef MULDIV_DIV_EN
            if (is_div) begin
                acc_d = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
                sh_d  = {sh_q[W-2:0], ~rem_diff[W]};
            end else
`endif
            begin
                acc_d = add_sum[W:1];
                sh_d  = {add_sum[0], sh_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sh_q  <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            m_q   <= m_d;
        end
    end

    assign res_hi = acc_q;
    assign res_lo = sh_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: FSM, iteration counter, sign handling and HI/LO registers.
// MULDIV_DIV_EN enables div/divu; without it a div request only pulses div_unsup.
//   state | meaning
//   IDLE  | accept start, mthi/mtlo writes land here
//   CALC  | ITER iteration steps on operand magnitudes
//   FIX   | sign-correct result, write HI/LO, pulse done
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = W
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           accept, dp_load, dp_step;
    logic           sgn_a, sgn_b;
    logic [W-1:0]   abs_a, abs_b, res_hi, res_lo;
    logic [2*W-1:0] prod;
`ifdef MULDIV_DIV_EN
    logic [1:0]     op_q, op_d;
    logic           sa_q, sa_d;
    logic           bz_q, bz_d;

    assign accept        = bus.start;
    assign bus.div_unsup = 1'b0;
`else
    logic           unsup_q, unsup_d;

    assign accept        = bus.start & ~op_is_div(bus.op);
    assign unsup_d       = (state_q == IDLE) & bus.start & op_is_div(bus.op);
    assign bus.div_unsup = unsup_q;
`endif

    assign sgn_a = op_is_signed(bus.op) & bus.a[W-1];
    assign sgn_b = op_is_signed(bus.op) & bus.b[W-1];
    assign abs_a = sgn_a ? -bus.a : bus.a;
    assign abs_b = sgn_b ? -bus.b : bus.b;
    assign prod  = {res_hi, res_lo};

    muldiv_dp #(.W(W)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (dp_load),
        .step   (dp_step),
`ifdef MULDIV_DIV_EN
        .is_div (op_q[1]),
`endif
        .opa    (abs_a),
        .opb    (abs_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
`ifdef MULDIV_DIV_EN
        op_d    = op_q;
        sa_d    = sa_q;
        bz_d    = bz_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    dp_load = 1'b1;
                    neg_d   = sgn_a ^ sgn_b;
`ifdef MULDIV_DIV_EN
                    op_d    = bus.op;
                    sa_d    = sgn_a;
                    bz_d    = (bus.b == '0);
`endif
                end else if (!bus.start) begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            CALC: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = FIX;
            end
            FIX: begin
`ifdef MULDIV_DIV_EN
                if (op_is_div(op_q)) begin
                    lo_d = neg_q ? -res_lo : res_lo;
                    hi_d = sa_q ? -res_hi : res_hi;
                    // divide by zero: quotient all ones, remainder already carries a
                    if (bz_q) lo_d = '1;
                end else
`endif
                begin
                    {hi_d, lo_d} = neg_q ? -prod : prod;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            op_q    <= '0;
            sa_q    <= 1'b0;
            bz_q    <= 1'b0;
`else
            unsup_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            op_q    <= op_d;
            sa_q    <= sa_d;
            bz_q    <= bz_d;
`else
            unsup_q <= unsup_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == FIX);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl; div cases run when MULDIV_DIV_EN is defined,
// otherwise the div_unsup path is exercised.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.W(32)) bus ();

    muldiv_ctrl #(.W(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          unsup_cnt = 0;
    logic        pend = 1'b0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT:  return sx * sy;
            MD_MULTU: return {32'b0, x} * {32'b0, y};
            MD_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // result checker: HI/LO are compared the cycle after done
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.div_unsup) unsup_cnt++;
        if (pend) begin
            check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                check("hilo", {bus.hi, bus.lo}, exp_v);
            end
        end
        pend = bus.done;
    end

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = h;
        bus.lo_we = l;
        bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] e, input logic we_clash);
        int n;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.hi_we = we_clash;
        bus.lo_we = we_clash;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("busy_rise", bus.busy, 1);
        n = 1;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 33);
        @(negedge clk);
        check("busy_fall", bus.busy, 0);
    endtask

`ifndef MULDIV_DIV_EN
    task automatic unsup_op(input logic [1:0] o);
        int   u0;
        logic busy_seen;
        u0        = unsup_cnt;
        busy_seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = 32'h10;
        bus.b     = 32'h3;
        @(negedge clk);
        bus.start = 1'b0;
        check("unsup_pulse", bus.div_unsup, 1);
        repeat (6) begin
            busy_seen = busy_seen | bus.busy;
            @(negedge clk);
        end
        check("unsup_busy", busy_seen, 0);
        check("unsup_count", unsup_cnt - u0, 1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          d0;
        logic [31:0] x, y;
        logic [1:0]  o;
        logic [63:0] e;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_unsup", bus.div_unsup, 0);
        rst = 1'b0;

        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op(MD_MULT,  32'h8000_0000, 32'h7FFF_FFFF, model(MD_MULT, 32'h8000_0000, 32'h7FFF_FFFF), 1'b0);
        run_op(MD_MULTU, 32'd0,         32'h1234_5678, 64'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = $urandom;
            o = i[0] ? MD_MULTU : MD_MULT;
            run_op(o, x, y, model(o, x, y), 1'b0);
        end

        mt_write(1'b1, 1'b1, 32'hA5A5_0001);
        check("mt_both_hi", bus.hi, 32'hA5A5_0001);
        check("mt_both_lo", bus.lo, 32'hA5A5_0001);
        mt_write(1'b1, 1'b0, 32'h0000_1234);
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_lo", bus.lo, 32'hA5A5_0001);
        run_op(MD_MULTU, 32'd10, 32'd20, 64'd200, 1'b1);

        // start held through a whole operation, mthi attempted mid-CALC
        e = model(MD_MULT, 32'd1234567, 32'hFFFF_0000);
        sb_q.push_back(e);
        sb_q.push_back(e);
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.a     = 32'd1234567;
        bus.b     = 32'hFFFF_0000;
        @(negedge clk);
        n = 1;
        while (!bus.done && n < 100) begin
            bus.hi_we = (n == 10);
            bus.wdata = 32'h0000_1234;
            @(negedge clk);
            n++;
        end
        bus.hi_we = 1'b0;
        check("hold_latency", n, 33);
        @(negedge clk);
        check("hold_busy_fall", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("hold_restart", bus.busy, 1);
        n = 1;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_latency2", n, 33);
        repeat (2) @(negedge clk);
        check("hold_done_cnt", done_cnt - d0, 2);

        // reset in the middle of CALC, then a fresh operation
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.a     = 32'd77;
        bus.b     = 32'd99;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        run_op(MD_MULT, 32'd77, 32'd99, 64'd7623, 1'b0);
        @(negedge clk);
        check("abort_done_cnt", done_cnt - d0, 1);

`ifdef MULDIV_DIV_EN
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_op(MD_DIVU, 32'd7,         32'd0,         {32'd7, 32'hFFFF_FFFF}, 1'b0);
        run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        run_op(MD_DIV,  32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}, 1'b0);
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = i[1] ? $urandom_range(1, 300) : $urandom;
            o = i[0] ? MD_DIVU : MD_DIV;
            run_op(o, x, y, model(o, x, y), 1'b0);
        end
        check("no_unsup", unsup_cnt, 0);
`else
        mt_write(1'b1, 1'b0, 32'h0000_1111);
        mt_write(1'b0, 1'b1, 32'h0000_2222);
        unsup_op(MD_DIV);
        unsup_op(MD_DIVU);
        check("unsup_hi", bus.hi, 32'h0000_1111);
        check("unsup_lo", bus.lo, 32'h0000_2222);
        run_op(MD_MULTU, 32'd6, 32'd7, 64'd42, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("sb_left", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
